// File: rtl/dac_axis_sample_unpacker.sv
// AXI4-Stream 64-bit IQ beat receiver: buffers beats in a small FIFO and replays
// them to the DAC datapath as one {I,Q} sample per clock, with priming and underflow stats.
//
// state    | meaning
// ST_IDLE  | playback disabled, no output
// ST_PRIME | waiting for enough buffered beats (or a buffered frame end)
// ST_PLAY0 | pop head beat and emit sample 0 (underflow if FIFO empty)
// ST_PLAY1 | emit sample 1 of the held beat
module dac_axis_sample_unpacker #(
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PRIME_LEVEL     = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXI_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  input  logic [7:0]                 s_axis_tkeep,
  output logic                       s_axis_tready,
  input  logic                       dac_enable,
  input  logic                       clear_stats,
  output logic [15:0]                dac_data_i,
  output logic [15:0]                dac_data_q,
  output logic                       dac_data_valid,
  output logic                       frame_done,
  output logic [15:0]                underflow_count,
  output logic                       keep_error,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_PLAY0, ST_PLAY1} state_t;
  state_t state, state_next;

  logic [AXI_DATA_WIDTH+1:0]  mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]              level, level_next;
  logic [LW-1:0]              tlast_cnt, tlast_cnt_next;
  logic                       tready_q;
  logic                       fifo_empty, beat_acc, keep_legal, wr_en, rd_en;
  logic [AXI_DATA_WIDTH+1:0]  head;
  logic                       head_last, head_half;
  logic [31:0]                hold_sample;
  logic                       hold_last;
  logic [31:0]                sample_next;
  logic                       valid_next, fd_next, uf_inc;

  assign fifo_empty = (level == '0);
  assign beat_acc   = s_axis_tvalid & tready_q;
  assign keep_legal = (s_axis_tkeep == 8'hFF) | ((s_axis_tkeep == 8'h0F) & s_axis_tlast);
  assign wr_en      = beat_acc & keep_legal;
  assign head       = mem[rd_ptr];
  assign head_last  = head[AXI_DATA_WIDTH+1];
  assign head_half  = head[AXI_DATA_WIDTH];

  always_ff @(posedge aclk) begin
    if (wr_en)
      mem[wr_ptr] <= {s_axis_tlast, (s_axis_tkeep == 8'h0F), s_axis_tdata};
  end

  always_comb begin
    level_next = level;
    if (wr_en && !rd_en)      level_next = level + 1'b1;
    else if (!wr_en && rd_en) level_next = level - 1'b1;
  end

  // Count of buffered frame ends lets PRIME start a short frame below the prime level.
  always_comb begin
    tlast_cnt_next = tlast_cnt;
    if ((wr_en && s_axis_tlast) && !(rd_en && head_last))      tlast_cnt_next = tlast_cnt + 1'b1;
    else if (!(wr_en && s_axis_tlast) && (rd_en && head_last)) tlast_cnt_next = tlast_cnt - 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      tlast_cnt <= '0;
      tready_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level     <= level_next;
      tlast_cnt <= tlast_cnt_next;
      tready_q  <= (level_next < DEPTH_L);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (dac_enable) state_next = ST_PRIME;
      ST_PRIME: begin
        if (!dac_enable)                                    state_next = ST_IDLE;
        else if ((level >= PRIME_L) || (tlast_cnt != '0))   state_next = ST_PLAY0;
      end
      ST_PLAY0: begin
        if (fifo_empty) begin
          if (!dac_enable) state_next = ST_IDLE;
        end else if (!head_half) begin
          state_next = ST_PLAY1;
        end else begin
          state_next = dac_enable ? ST_PRIME : ST_IDLE;
        end
      end
      ST_PLAY1: begin
        if (hold_last) state_next = dac_enable ? ST_PRIME : ST_IDLE;
        else           state_next = dac_enable ? ST_PLAY0 : ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en       = 1'b0;
    valid_next  = 1'b0;
    fd_next     = 1'b0;
    uf_inc      = 1'b0;
    sample_next = '0;
    case (state)
      ST_PLAY0: begin
        if (fifo_empty) begin
          uf_inc = 1'b1;
        end else begin
          rd_en       = 1'b1;
          valid_next  = 1'b1;
          sample_next = head[31:0];
          fd_next     = head_half & head_last;
        end
      end
      ST_PLAY1: begin
        valid_next  = 1'b1;
        sample_next = hold_sample;
        fd_next     = hold_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dac_data_valid <= 1'b0;
      dac_data_i     <= '0;
      dac_data_q     <= '0;
      frame_done     <= 1'b0;
      hold_sample    <= '0;
      hold_last      <= 1'b0;
    end else begin
      dac_data_valid <= valid_next;
      dac_data_i     <= sample_next[31:16];
      dac_data_q     <= sample_next[15:0];
      frame_done     <= fd_next;
      if (rd_en) begin
        hold_sample <= head[AXI_DATA_WIDTH-1:32];
        hold_last   <= head_last;
      end
    end
  end

  // clear_stats wins over a same-cycle increment or error.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      underflow_count <= '0;
      keep_error      <= 1'b0;
    end else if (clear_stats) begin
      underflow_count <= '0;
      keep_error      <= 1'b0;
    end else begin
      if (uf_inc && (underflow_count != 16'hFFFF)) underflow_count <= underflow_count + 1'b1;
      if (beat_acc && !keep_legal)                 keep_error      <= 1'b1;
    end
  end

  assign s_axis_tready = tready_q;
  assign fifo_level    = level;

endmodule

// File: tb/tb_dac_axis_sample_unpacker.sv
// Self-checking bench for dac_axis_sample_unpacker: directed steps plus random beats,
// with every played sample compared against a queue of expected samples.
module tb_dac_axis_sample_unpacker;

  typedef logic [32:0] smp_t;  // {I, Q, frame_end}

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tready;
  logic        dac_enable = 1'b0;
  logic        clear_stats = 1'b0;
  logic [15:0] dac_data_i, dac_data_q;
  logic        dac_data_valid, frame_done;
  logic [15:0] underflow_count;
  logic        keep_error;
  logic [4:0]  fifo_level;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  logic out_of_reset = 1'b0;
  logic exp_kerr = 1'b0;
  smp_t exp_q[$];
  int   vcyc[$];

  dac_axis_sample_unpacker #(
    .AXI_DATA_WIDTH(64), .FIFO_DEPTH_LOG2(4), .PRIME_LEVEL(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tready(s_axis_tready),
    .dac_enable(dac_enable), .clear_stats(clear_stats),
    .dac_data_i(dac_data_i), .dac_data_q(dac_data_q),
    .dac_data_valid(dac_data_valid), .frame_done(frame_done),
    .underflow_count(underflow_count), .keep_error(keep_error),
    .fifo_level(fifo_level)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    out_of_reset <= aresetn;
  end

  // Output monitor: every valid sample must be the next expected one.
  always @(negedge aclk) begin
    if (dac_data_valid) begin
      vcyc.push_back(cyc);
      if (frame_done) fd_cnt++;
      if (exp_q.size() == 0) chk("unexpected_sample_qdepth", 64'(exp_q.size()), 64'd1);
      else chk("sample", 64'({dac_data_i, dac_data_q, frame_done}), 64'(exp_q.pop_front()));
    end else begin
      chk("idle_outputs_zero", 64'({dac_data_i, dac_data_q, frame_done}), 64'd0);
    end
    if (aresetn && out_of_reset)
      chk("tready_vs_level", 64'(s_axis_tready), 64'(fifo_level < 5'd16));
  end

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic model_push(input logic [63:0] d, input logic [7:0] k, input logic l);
    if (k == 8'hFF) begin
      exp_q.push_back({d[31:16], d[15:0], 1'b0});
      exp_q.push_back({d[63:48], d[47:32], l});
    end else if (k == 8'h0F && l) begin
      exp_q.push_back({d[31:16], d[15:0], 1'b1});
    end else begin
      exp_kerr = 1'b1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           output int acc_cyc);
    int n = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin step(); n++; end
    chk("send_accept", 64'(s_axis_tready), 64'd1);
    step();
    acc_cyc = cyc;
    if (n < 200) model_push(d, k, l);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_samples(input int target, input int budget);
    int n = 0;
    while (vcyc.size() < target && n < budget) begin step(); n++; end
    chk("wait_samples", 64'(vcyc.size() >= target), 64'd1);
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1; step(); clear_stats = 1'b0;
  endtask

  initial begin
    int base, fd0, acc, b, n;
    logic rdy;
    logic [63:0] d;
    logic [63:0] bp_data [20];
    logic [7:0] k;
    logic l;

    // Reset state
    repeat (3) step();
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_valid", 64'(dac_data_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_uf", 64'(underflow_count), 64'd0);
    chk("rst_kerr", 64'(keep_error), 64'd0);
    aresetn = 1'b1;
    step();
    chk("tready_after_release", 64'(s_axis_tready), 64'd1);

    // Basic playback: 4 beats, 8 consecutive samples, frame_done on the 8th
    dac_enable = 1'b1;
    base = vcyc.size(); fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) begin
      d = {16'(4*i+1), 16'(4*i+2), 16'(4*i+3), 16'(4*i+4)};
      send_beat(d, 8'hFF, i == 3, acc);
    end
    wait_samples(base + 8, 60);
    repeat (3) step();
    chk("basic_count", 64'(vcyc.size()), 64'(base + 8));
    chk("basic_contiguous", 64'(vcyc[base+7] - vcyc[base]), 64'd7);
    chk("basic_frames", 64'(fd_cnt), 64'(fd0 + 1));

    // Half beat after returning to PRIME: one sample, latency 2, frame_done on it
    base = vcyc.size(); fd0 = fd_cnt;
    send_beat(64'hDEAD_BEEF_1234_5678, 8'h0F, 1'b1, acc);
    wait_samples(base + 1, 20);
    repeat (4) step();
    chk("half_count", 64'(vcyc.size()), 64'(base + 1));
    chk("half_latency", 64'(vcyc[base]), 64'(acc + 2));
    chk("half_frame", 64'(fd_cnt), 64'(fd0 + 1));

    // Full single tlast beat: sample 0 at +2, sample 1 at +3
    base = vcyc.size();
    send_beat(64'hA5A5_0101_5A5A_0202, 8'hFF, 1'b1, acc);
    wait_samples(base + 2, 20);
    chk("lat_s0", 64'(vcyc[base]), 64'(acc + 2));
    chk("lat_s1", 64'(vcyc[base+1]), 64'(acc + 3));

    // Illegal tkeep handling
    pulse_clear();
    chk("kerr_cleared", 64'(keep_error), 64'd0);
    base = vcyc.size();
    send_beat(64'h1111_2222_3333_4444, 8'h0F, 1'b0, acc);
    step();
    chk("kerr_0f_nolast", 64'(keep_error), 64'd1);
    chk("kerr_level", 64'(fifo_level), 64'd0);
    send_beat(64'h5555_6666_7777_8888, 8'h3C, 1'b1, acc);
    repeat (6) step();
    chk("kerr_sticky", 64'(keep_error), 64'd1);
    chk("kerr_no_samples", 64'(vcyc.size()), 64'(base));
    clear_stats = 1'b1;
    send_beat(64'h9999_AAAA_BBBB_CCCC, 8'h01, 1'b1, acc);
    clear_stats = 1'b0;
    chk("clear_priority_kerr", 64'(keep_error), 64'd0);
    exp_kerr = 1'b0;

    // Underflow: 4 beats play out, 5 starved cycles, resume without re-prime
    pulse_clear();
    chk("uf_cleared", 64'(underflow_count), 64'd0);
    base = vcyc.size();
    for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0, acc);
    wait_samples(base + 8, 60);
    repeat (4) step();
    send_beat({$urandom, $urandom}, 8'hFF, 1'b1, acc);
    chk("uf_count5", 64'(underflow_count), 64'd5);
    wait_samples(base + 10, 20);
    chk("uf_gap", 64'(vcyc[base+8] - vcyc[base+7]), 64'd6);
    chk("uf_resume_latency", 64'(vcyc[base+8]), 64'(acc + 1));
    repeat (5) step();
    chk("uf_hold", 64'(underflow_count), 64'd5);
    pulse_clear();
    chk("uf_clear", 64'(underflow_count), 64'd0);

    // Backpressure: 20 beats with playback disabled
    dac_enable = 1'b0;
    repeat (2) step();
    base = vcyc.size(); fd0 = fd_cnt;
    for (int i = 0; i < 20; i++) bp_data[i] = {$urandom, $urandom};
    b = 0;
    for (int c = 0; c < 20; c++) begin
      s_axis_tdata = bp_data[b]; s_axis_tkeep = 8'hFF; s_axis_tlast = (b == 19); s_axis_tvalid = 1'b1;
      rdy = s_axis_tready;
      step();
      if (rdy) begin model_push(bp_data[b], 8'hFF, b == 19); b++; end
    end
    chk("bp_accepts", 64'(b), 64'd16);
    chk("bp_level", 64'(fifo_level), 64'd16);
    chk("bp_tready_low", 64'(s_axis_tready), 64'd0);
    dac_enable = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 20) begin step(); n++; end
    chk("bp_reassert_delay", 64'(n), 64'd3);
    chk("bp_reassert_level", 64'(fifo_level), 64'd15);
    for (int i = b; i < 20; i++) send_beat(bp_data[i], 8'hFF, i == 19, acc);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin step(); n++; end
    repeat (3) step();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_samples", 64'(vcyc.size()), 64'(base + 40));
    chk("bp_frames", 64'(fd_cnt), 64'(fd0 + 1));

    // Random beats, keep patterns and idle gaps
    pulse_clear();
    exp_kerr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      n = int'($urandom_range(0, 9));
      k = (n < 7) ? 8'hFF : (n < 8) ? 8'h0F : 8'($urandom);
      l = ($urandom_range(0, 5) == 0);
      if (i == 29) begin k = 8'hFF; l = 1'b1; end
      send_beat({$urandom, $urandom}, k, l, acc);
      repeat ($urandom_range(0, 2)) step();
    end
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin step(); n++; end
    repeat (3) step();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_kerr", 64'(keep_error), 64'(exp_kerr));

    // Enable drop on a phase-0 cycle
    base = vcyc.size(); fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0, acc);
    wait_samples(base + 1, 30);
    step();
    dac_enable = 1'b0;
    repeat (12) step();
    chk("drop_samples", 64'(vcyc.size()), 64'(base + 4));
    chk("drop_level", 64'(fifo_level), 64'd2);
    chk("drop_no_frame", 64'(fd_cnt), 64'(fd0));

    // Async reset mid-frame
    dac_enable = 1'b1;
    base = vcyc.size();
    send_beat({$urandom, $urandom}, 8'hFF, 1'b1, acc);
    wait_samples(base + 2, 40);
    aresetn = 1'b0;
    #1;
    chk("arst_valid", 64'(dac_data_valid), 64'd0);
    chk("arst_iq", 64'({dac_data_i, dac_data_q}), 64'd0);
    chk("arst_fd", 64'(frame_done), 64'd0);
    chk("arst_tready", 64'(s_axis_tready), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_uf", 64'(underflow_count), 64'd0);
    exp_q.delete();
    #1;
    aresetn = 1'b1;
    base = vcyc.size(); fd0 = fd_cnt;
    step();
    chk("arst_tready_release", 64'(s_axis_tready), 64'd1);
    repeat (10) step();
    chk("arst_no_frame", 64'(fd_cnt), 64'(fd0));
    chk("arst_no_samples", 64'(vcyc.size()), 64'(base));
    chk("arst_level_after", 64'(fifo_level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_axis_sample_unpacker.md
Name: dac_axis_sample_unpacker

Overview:
- AXI4-Stream slave that receives 64-bit sample beats from the host/packet side. Each beat carries two 32-bit {I[15:0],Q[15:0]} samples.
- Buffers beats in an internal FIFO and replays them to the DAC datapath at one 32-bit sample per clock, with frame (tlast) tracking, priming and underflow accounting.
- Sits on the transmit side: it is the receiving end of the same 64-bit IQ stream format the ADC capture path emits, feeding the DAC/loopback.

Parameters:
- AXI_DATA_WIDTH, 64, stream data width; only 64 is supported.
- FIFO_DEPTH_LOG2, 4, FIFO depth = 2^FIFO_DEPTH_LOG2 beats (16).
- PRIME_LEVEL, 4, beats that must be buffered before playback starts (1..2^FIFO_DEPTH_LOG2).

Ports:
- aclk  in  1  single clock for all logic
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  64  [31:0] = sample 0 (emitted first), [63:32] = sample 1
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_tkeep  in  8  byte enables
- s_axis_tready  out  1  beat accepted when tvalid & tready at a rising edge
- dac_enable  in  1  playback enable, level-sensitive
- clear_stats  in  1  synchronous clear of underflow_count and keep_error
- dac_data_i  out  16  I of the current sample
- dac_data_q  out  16  Q of the current sample
- dac_data_valid  out  1  sample valid
- frame_done  out  1  one-cycle pulse with the last sample of a tlast beat
- underflow_count  out  16  saturating count of starved PLAY cycles
- keep_error  out  1  sticky flag for a dropped illegal beat
- fifo_level  out  FIFO_DEPTH_LOG2+1  beats currently buffered

Behaviour:
- Reset (aresetn low, async): FIFO empty, state IDLE. All outputs are 0, including s_axis_tready. s_axis_tready goes high on the first edge after reset release.
- FIFO entry = {tlast, half, data[63:0]}.
- s_axis_tready = (fifo_level < 2^FIFO_DEPTH_LOG2), computed from the registered level. A full FIFO never accepts, even when a read happens in the same cycle.
- A write and a read in the same cycle leave the level unchanged.
- tkeep rules:
  - 8'hFF: both samples are valid.
  - 8'h0F: only sample 0 is valid (half = 1). Legal only with tlast = 1.
  - Any other value, or 8'h0F without tlast: the beat is accepted but dropped (not written), and keep_error sets.
- FSM states:
  - IDLE: no output. Go to PRIME when dac_enable = 1.
  - PRIME: no output. Go to PLAY when fifo_level >= PRIME_LEVEL, or when any buffered beat has tlast = 1. Go to IDLE if dac_enable = 0.
  - PLAY, phase 0: pop the head beat and emit sample 0.
  - PLAY, phase 1: emit sample 1 from the held beat. Skipped if half = 1.
  - Each sample is emitted for exactly one cycle.
- Frame end: frame_done is asserted in the same cycle as the last emitted sample of a beat with tlast = 1. Next state is PRIME if dac_enable = 1, else IDLE.
- dac_enable falls mid-frame: the current beat's remaining sample is still emitted, then the FSM goes to IDLE. Remaining FIFO contents are retained.
- Underflow: in PLAY phase 0 with the FIFO empty:
  - dac_data_valid = 0 and dac_data_i/q = 0.
  - underflow_count increments, saturating at 16'hFFFF.
  - The FSM stays in PLAY and resumes on the first available beat with no re-prime.
- Latency: with PRIME_LEVEL = 1, a beat accepted at edge N (state PRIME) gives dac_data_valid = 1 with sample 0 after edge N+2, and sample 1 after edge N+3.
- Outputs are registered. When dac_data_valid = 0, dac_data_i/q are 0.
- clear_stats takes priority over an increment in the same cycle.
- keep_error and underflow_count survive frame boundaries. Only reset or clear_stats clears them.

Test Plan:
- Basic playback: PRIME_LEVEL = 4, dac_enable = 1, send 4 beats with tkeep = FF, data = {32'h0001_0002, 32'h0003_0004} … and tlast on beat 4.
  - Required: 8 consecutive valid samples, starting I = 16'h0003, Q = 16'h0004.
  - Required: frame_done exactly on sample 8, then the FSM returns to PRIME.
- Backpressure: dac_enable = 0, push 20 beats.
  - Required: tready drops after 16 accepts and fifo_level = 16.
  - Enable playback: tready reasserts one cycle after the first pop, and no beat is lost or duplicated (checked by scoreboard).
- Half beat: final beat with tkeep = 0F, tlast = 1.
  - Required: only sample 0 is emitted, frame_done on it, no sample 1.
  - Repeat with tkeep = 0F and tlast = 0: the beat is dropped and keep_error = 1.
- Underflow: PRIME_LEVEL = 1, send 1 beat, then stall for 5 cycles, then send 1 beat.
  - Required: 2 valid samples, then 5 invalid cycles with underflow_count = 5, then resume.
  - Required: clear_stats brings the count back to 0.
- Enable drop mid-beat: deassert dac_enable on a phase-0 cycle.
  - Required: the phase-1 sample is still emitted, then the FSM goes to IDLE with fifo_level unchanged afterwards.
- Async reset mid-frame: pulse aresetn low between edges.
  - Required: all outputs are 0 immediately and fifo_level = 0.
  - Required: tready = 1 on the first edge after release, and there is no spurious frame_done.
